// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial stage with one-word holding register
//
// Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one
// bit per clock on d. A single holding register lets a second word wait while
// the current one shifts, so consecutive words stream with no idle gap.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   in_valid  in_data holds a word to send
//   in_data   word to serialize (WIDTH bits)
//   in_ready  a word can be accepted this cycle (registers only)
//   d         serial output, 0 when idle
//   busy      a word is being shifted out
//   words     count of fully transmitted words, modulo 256
//
// Build option: define SER_LSB_FIRST_EN to transmit LSB first (default MSB first).

module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             d,
    output logic             busy,
    output logic [7:0]       words
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [CW-1:0]    bitcnt;

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] shifted;
    logic             out_bit;

`ifdef SER_LSB_FIRST_EN
    assign shifted = {1'b0, shreg[WIDTH-1:1]};
    assign out_bit = shreg[0];
`else
    assign shifted = {shreg[WIDTH-2:0], 1'b0};
    assign out_bit = shreg[WIDTH-1];
`endif

    // in_ready never looks at in_valid, so it is free of input glitches.
    assign in_ready = !hold_full;
    assign accept   = in_valid && in_ready;
    assign last     = (state_q == SHIFT) && (bitcnt == LAST_BIT);
    assign busy     = (state_q == SHIFT);
    assign d        = (state_q == SHIFT) && out_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // On the last bit, stay only if another word is ready to go.
                if (last && !hold_full && !accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            bitcnt    <= '0;
            words     <= 8'd0;
        end else begin
            if (state_q == IDLE) begin
                if (accept) begin
                    shreg  <= in_data;
                    bitcnt <= '0;
                end
            end else if (!last) begin
                shreg  <= shifted;
                bitcnt <= bitcnt + CW'(1);
                if (accept) begin
                    hold      <= in_data;
                    hold_full <= 1'b1;
                end
            end else begin
                words <= words + 8'd1;
                // hold_full blocks acceptance here, so the drain and a new
                // word never compete for hold in the same cycle.
                if (hold_full) begin
                    shreg     <= hold;
                    hold_full <= 1'b0;
                    bitcnt    <= '0;
                end else if (accept) begin
                    shreg  <= in_data;
                    bitcnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - self-checking bench for bit_serializer

module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         d;
    logic         busy;
    logic [7:0]   words;

    int           errors = 0;
    int           checks = 0;
    bit           exp_q[$];
    logic [7:0]   exp_words = 8'd0;

    bit_serializer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .d        (d),
        .busy     (busy),
        .words    (words)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every busy cycle consumes one expected bit.
    initial begin
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bit_underflow: d=%b while busy, expected no bit pending", d);
                end else begin
                    bit e;
                    e = exp_q.pop_front();
                    if (d !== e) begin
                        errors++;
                        $display("FAIL serial_bit at %0t: d=%b expected %b", $time, d, e);
                    end
                end
            end else if (rst === 1'b0) begin
                checks++;
                if (d !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_d at %0t: d=%b expected 0", $time, d);
                end
            end
        end
    end

    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
`ifdef SER_LSB_FIRST_EN
            exp_q.push_back(w[i]);
`else
            exp_q.push_back(w[W-1-i]);
`endif
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input logic [W-1:0] w, output int waited);
        waited = 0;
        in_data = w;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b expected 1 within 100 cycles", in_ready);
            in_valid = 1'b0;
        end else begin
            push_word(w);
            exp_words = exp_words + 8'd1;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b expected 0", name, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_bits_left: %0d bits not seen, expected 0", name, exp_q.size());
        end
        checks++;
        if (words !== exp_words) begin
            errors++;
            $display("FAIL %s_words: words=%0d expected %0d", name, words, exp_words);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({d, busy, in_ready, words} !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL reset_outputs: d=%b busy=%b in_ready=%b words=%0d expected 0 0 1 0",
                     d, busy, in_ready, words);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_words = 8'd0;
        @(negedge clk);
        checks++;
        if ({d, busy, in_ready, words} !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL after_reset_outputs: d=%b busy=%b in_ready=%b words=%0d expected 0 0 1 0",
                     d, busy, in_ready, words);
        end
    endtask

    task automatic test_single();
        int waited;
        send_word(8'h2B, waited);
        in_valid = 1'b0;
        // now in cycle 1 after the accepting edge
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (busy !== (k <= 8)) begin
                errors++;
                $display("FAIL single_busy cycle %0d: busy=%b expected %b", k, busy, (k <= 8));
            end
            @(negedge clk);
        end
        wait_idle("single");
    endtask

    task automatic test_back_to_back();
        int waited;
        send_word(8'hA5, waited);
        send_word(8'h3C, waited);
        in_valid = 1'b0;
        // now in cycle 2 after the first accepting edge
        for (int k = 2; k <= 21; k++) begin
            checks++;
            if (busy !== (k <= 16)) begin
                errors++;
                $display("FAIL b2b_busy cycle %0d: busy=%b expected %b", k, busy, (k <= 16));
            end
            checks++;
            if (in_ready !== (k >= 9)) begin
                errors++;
                $display("FAIL b2b_in_ready cycle %0d: in_ready=%b expected %b", k, in_ready, (k >= 9));
            end
            @(negedge clk);
        end
        wait_idle("b2b");
    endtask

    task automatic test_three_queued();
        int waited;
        send_word(8'hC3, waited);
        send_word(8'h5A, waited);
        send_word(8'h96, waited);
        in_valid = 1'b0;
        checks++;
        if (waited != 7) begin
            errors++;
            $display("FAIL three_stall: third word waited %0d cycles expected 7", waited);
        end
        wait_idle("three");
    endtask

    task automatic test_reset_abort();
        int waited;
        send_word(8'hFF, waited);
        send_word(8'h0F, waited);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // cycle 4: fourth bit of 8'hFF already checked by the monitor
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        exp_words = 8'd0;
        checks++;
        if ({d, busy, in_ready, words} !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL abort_outputs: d=%b busy=%b in_ready=%b words=%0d expected 0 0 1 0",
                     d, busy, in_ready, words);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if ({d, busy, in_ready} !== 3'b001) begin
                errors++;
                $display("FAIL abort_residual cycle %0d: d=%b busy=%b in_ready=%b expected 0 0 1",
                         k, d, busy, in_ready);
            end
        end
        wait_idle("abort");
    endtask

    task automatic test_wrap();
        int waited;
        for (int i = 0; i < 255; i++) begin
            send_word(W'($urandom_range(0, 255)), waited);
        end
        in_valid = 1'b0;
        wait_idle("wrap255");
        send_word(8'h81, waited);
        in_valid = 1'b0;
        wait_idle("wrap256");
        checks++;
        if (words !== 8'd0) begin
            errors++;
            $display("FAIL wrap_zero: words=%0d expected 0", words);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_three_queued();
        test_reset_abort();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
